amo_resv_shim: RTL

AMO_RESV_SHIM -- requirements
Module: amo_resv_shim

---
 rtl/amo_resv_shim.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/amo_resv_shim.sv
// AMO / LR-SC shim placed in front of one single-ported SRAM bank.
// Plain loads and stores pass straight through. An AMO takes two cycles:
// a read in Idle, then a read-modify-write commit in DoAMO.
// LR/SC reservations are kept in a table with one entry per requester ID.
module amo_resv_shim #(
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned NumCores     = 8,
    parameter int unsigned IdWidth      = $clog2(NumCores)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_req_i,
    output logic                    in_gnt_o,
    input  logic [AddrMemWidth-1:0] in_add_i,
    input  logic [3:0]              in_amo_i,
    input  logic                    in_wen_i,
    input  logic [DataWidth-1:0]    in_wdata_i,
    input  logic [DataWidth/8-1:0]  in_be_i,
    input  logic [IdWidth-1:0]      in_id_i,
    output logic                    in_rvalid_o,
    output logic [DataWidth-1:0]    in_rdata_o,
    output logic                    out_req_o,
    output logic [AddrMemWidth-1:0] out_add_o,
    output logic                    out_wen_o,
    output logic [DataWidth-1:0]    out_wdata_o,
    output logic [DataWidth/8-1:0]  out_be_o,
    input  logic [DataWidth-1:0]    out_rdata_i
);

    localparam int unsigned BeWidth = DataWidth / 8;

    localparam logic [3:0] AMO_NONE = 4'h0;
    localparam logic [3:0] AMO_SWAP = 4'h1;
    localparam logic [3:0] AMO_ADD  = 4'h2;
    localparam logic [3:0] AMO_AND  = 4'h3;
    localparam logic [3:0] AMO_OR   = 4'h4;
    localparam logic [3:0] AMO_XOR  = 4'h5;
    localparam logic [3:0] AMO_MAX  = 4'h6;
    localparam logic [3:0] AMO_MAXU = 4'h7;
    localparam logic [3:0] AMO_MIN  = 4'h8;
    localparam logic [3:0] AMO_MINU = 4'h9;
    localparam logic [3:0] AMO_CAS  = 4'hA;
    localparam logic [3:0] AMO_LR   = 4'hB;
    localparam logic [3:0] AMO_SC   = 4'hC;

    typedef enum logic {ST_IDLE, ST_DOAMO} state_e;

    // Place a 32-bit word into the selected half of the bank word, zeroing the other half.
    function automatic logic [DataWidth-1:0] place_word(input logic [31:0] word, input logic upper);
        logic [DataWidth-1:0] res;
        res = '0;
        if (upper && (DataWidth == 64)) res[DataWidth-1 -: 32] = word;
        else                            res[31:0] = word;
        return res;
    endfunction

    // Byte enables covering the selected 32-bit word.
    function automatic logic [BeWidth-1:0] word_be(input logic upper);
        logic [BeWidth-1:0] res;
        res = '0;
        if (upper && (DataWidth == 64)) res[BeWidth-1 -: 4] = 4'hF;
        else                            res[3:0] = 4'hF;
        return res;
    endfunction

    // 32-bit AMO ALU. Unsigned ordering comes from the borrow of a 33-bit subtraction.
    function automatic logic [31:0] amo_alu(input logic [3:0] op, input logic [31:0] old_w,
                                            input logic [31:0] opnd, input logic [31:0] swap_w);
        logic signed [31:0] s_old;
        logic signed [31:0] s_opnd;
        logic [32:0]        diff;
        logic               lt_s;
        logic               lt_u;
        logic [31:0]        res;
        s_old  = old_w;
        s_opnd = opnd;
        diff   = {1'b0, old_w} - {1'b0, opnd};
        lt_u   = diff[32];
        lt_s   = (s_old < s_opnd);
        case (op)
            AMO_SWAP: res = opnd;
            AMO_ADD:  res = old_w + opnd;
            AMO_AND:  res = old_w & opnd;
            AMO_OR:   res = old_w | opnd;
            AMO_XOR:  res = old_w ^ opnd;
            AMO_MAX:  res = lt_s ? opnd : old_w;
            AMO_MAXU: res = lt_u ? opnd : old_w;
            AMO_MIN:  res = lt_s ? old_w : opnd;
            AMO_MINU: res = lt_u ? old_w : opnd;
            AMO_CAS:  res = (old_w == opnd) ? swap_w : old_w;
            default:  res = old_w;
        endcase
        return res;
    endfunction

    state_e                  r_state;
    state_e                  w_next_state;
    logic [3:0]              r_amo_op;
    logic [AddrMemWidth-1:0] r_addr;
    logic [31:0]             r_operand;
    logic [31:0]             r_swap;
    logic                    r_upper;
    logic                    r_rvalid;
    logic                    r_sc_rsp;
    logic                    r_sc_fail;
    logic                    r_sc_upper;
    logic [NumCores-1:0]     r_resv_vld;
    logic [AddrMemWidth-1:0] r_resv_addr [NumCores];

    logic                    w_sel_upper;
    logic [31:0]             w_wd_hi;
    logic [31:0]             w_wd_sel;
    logic [31:0]             w_opnd_in;
    logic [31:0]             w_old_word;
    logic [31:0]             w_alu_res;
    logic                    w_is_amo;
    logic                    w_sc_ok;
    logic                    w_amo_start;
    logic                    w_resv_set;
    logic                    w_sc_go;
    logic                    w_commit;
    logic [AddrMemWidth-1:0] w_commit_addr;

    generate
        if (DataWidth == 64) begin : g_dw64
            assign w_sel_upper = in_be_i[4];
            assign w_wd_hi     = in_wdata_i[DataWidth-1 -: 32];
            assign w_old_word  = r_upper ? out_rdata_i[DataWidth-1 -: 32] : out_rdata_i[31:0];
        end else begin : g_dw32
            assign w_sel_upper = 1'b0;
            assign w_wd_hi     = 32'h0;
            assign w_old_word  = out_rdata_i[31:0];
        end
    endgenerate

    assign w_is_amo    = (in_amo_i >= AMO_SWAP) && (in_amo_i <= AMO_CAS);
    assign w_wd_sel    = w_sel_upper ? w_wd_hi : in_wdata_i[31:0];
    assign w_opnd_in   = (in_amo_i == AMO_CAS) ? in_wdata_i[31:0] : w_wd_sel;
    assign w_sc_ok     = r_resv_vld[in_id_i] && (r_resv_addr[in_id_i] == in_add_i);
    assign w_alu_res   = amo_alu(r_amo_op, w_old_word, r_operand, r_swap);
    assign in_rvalid_o = r_rvalid;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next state, handshake and SRAM port steering; SC/LR/store side effects decoded here.
    always_comb begin
        w_next_state  = r_state;
        in_gnt_o      = 1'b0;
        out_req_o     = 1'b0;
        out_add_o     = in_add_i;
        out_wen_o     = in_wen_i;
        out_wdata_o   = in_wdata_i;
        out_be_o      = in_be_i;
        w_amo_start   = 1'b0;
        w_resv_set    = 1'b0;
        w_sc_go       = 1'b0;
        w_commit      = 1'b0;
        w_commit_addr = in_add_i;
        case (r_state)
            ST_IDLE: begin
                in_gnt_o  = in_req_i;
                out_req_o = in_req_i;
                if (in_req_i) begin
                    if (w_is_amo) begin
                        out_wen_o    = 1'b0;
                        w_amo_start  = 1'b1;
                        w_next_state = ST_DOAMO;
                    end else if (in_amo_i == AMO_LR) begin
                        out_wen_o  = 1'b0;
                        w_resv_set = 1'b1;
                    end else if (in_amo_i == AMO_SC) begin
                        w_sc_go = 1'b1;
                        if (w_sc_ok) begin
                            out_wen_o = 1'b1;
                            w_commit  = 1'b1;
                        end else begin
                            out_req_o = 1'b0;
                        end
                    end else if (in_wen_i) begin
                        w_commit = 1'b1;
                    end
                end
            end
            ST_DOAMO: begin
                // A reset landing on the commit cycle must keep the write off the bank.
                out_req_o     = !rst_i;
                out_wen_o     = 1'b1;
                out_add_o     = r_addr;
                out_wdata_o   = place_word(w_alu_res, r_upper);
                out_be_o      = word_be(r_upper);
                w_commit      = !rst_i;
                w_commit_addr = r_addr;
                w_next_state  = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Response data: old word during the AMO commit, SC status after an SC, else SRAM data.
    always_comb begin
        in_rdata_o = out_rdata_i;
        if (r_state == ST_DOAMO) in_rdata_o = place_word(w_old_word, r_upper);
        else if (r_sc_rsp)       in_rdata_o = place_word({31'h0, r_sc_fail}, r_sc_upper);
    end

    // Control registers: response valid, pending SC status and the latched opcode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_sc_rsp <= 1'b0;
            r_amo_op <= AMO_NONE;
        end else begin
            r_rvalid <= in_req_i && in_gnt_o;
            r_sc_rsp <= w_sc_go;
            if (w_amo_start)               r_amo_op <= in_amo_i;
            else if (r_state == ST_DOAMO)  r_amo_op <= AMO_NONE;
        end
    end

    // AMO operands and SC status capture; data only, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_amo_start) begin
            r_addr    <= in_add_i;
            r_operand <= w_opnd_in;
            r_swap    <= w_wd_hi;
            r_upper   <= (in_amo_i == AMO_CAS) ? 1'b0 : w_sel_upper;
        end
        if (w_sc_go) begin
            r_sc_fail  <= !w_sc_ok;
            r_sc_upper <= w_sel_upper;
        end
    end

    // Reservation table: committed writes kill matching entries; an LR set, issued later, wins for its own ID.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resv_vld <= '0;
        end else begin
            for (int i = 0; i < NumCores; i++) begin
                if (w_commit && r_resv_vld[i] && (r_resv_addr[i] == w_commit_addr)) r_resv_vld[i] <= 1'b0;
            end
            if (w_resv_set) begin
                r_resv_vld[in_id_i]  <= 1'b1;
                r_resv_addr[in_id_i] <= in_add_i;
            end
        end
    end

endmodule
